escalonador_placar: RTL



---
 rtl/placar_pkg.sv | 40 ++++
 rtl/placar_acumulador.sv | 45 ++++
 rtl/escalonador_placar.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/placar_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | placar_pkg                                                                 |
// | Shared constants and types for the scoreboard digit scan sequencer.        |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
package placar_pkg;

  // Number of score-digit positions; position N_DIGITS is the most significant
  localparam int N_DIGITS = 7;

  // Width of one recognized digit as returned by the engine
  localparam int DIGIT_W = 4;

  // Code substituted for a digit the engine could not read or never answered
  localparam logic [DIGIT_W-1:0] INVALID_DIGIT = 4'hF;

  // Binary score width; 10^N_DIGITS - 1 must fit
  localparam int SCORE_W = 24;

  // Maximum cycles spent waiting on the engine for a single job
  localparam int TIMEOUT = 1023;

  // Scan sequencer states
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT    = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } state_e;

  // A recognized digit is usable only when it is a decimal value
  function automatic logic digit_is_valid(input logic [DIGIT_W-1:0] d);
    return (d <= 4'd9);
  endfunction

endpackage : placar_pkg
`default_nettype wire

// File: rtl/placar_acumulador.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | placar_acumulador                                                          |
// | Decimal-to-binary score accumulator: acc <= acc*10 + digit, MSD first.     |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module placar_acumulador #(
  parameter int SCORE_W = placar_pkg::SCORE_W
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clear_i,
  input  logic                             enable_i,
  input  logic [placar_pkg::DIGIT_W-1:0]   digit_i,
  output logic [SCORE_W-1:0]               acc_o
);
  import placar_pkg::*;

  logic [SCORE_W-1:0] acc_q;
  logic [SCORE_W-1:0] acc_d;

  // Next accumulator value: clear wins over enable; x10 built from two shifts
  always_comb begin
    acc_d = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (enable_i) begin
      acc_d = (acc_q << 3) + (acc_q << 1) + SCORE_W'(digit_i);
    end
  end

  // Accumulator register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule : placar_acumulador
`default_nettype wire

// File: rtl/escalonador_placar.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | escalonador_placar                                                         |
// | Time-shares one digit-recognition engine across the scoreboard digit       |
// | positions, scanning MSD to LSD once per trigger and publishing the digits  |
// | and the accumulated binary score.                                          |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module escalonador_placar #(
  parameter int N_DIGITS = placar_pkg::N_DIGITS,
  parameter int TIMEOUT  = placar_pkg::TIMEOUT,
  parameter int SCORE_W  = placar_pkg::SCORE_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  trigger,
  output logic                  eng_start,
  output logic [2:0]            eng_sel,
  input  logic                  eng_done,
  input  logic [3:0]            eng_digit,
  output logic [4*N_DIGITS-1:0] digitos,
  output logic [SCORE_W-1:0]    score,
  output logic                  score_valid,
  output logic                  busy,
  output logic                  error
);
  import placar_pkg::*;

  localparam int                 TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0]   TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [2:0]         IDX_MSD  = 3'(N_DIGITS);

  state_e                 state_q, state_d;
  logic [2:0]             idx_q, idx_d;
  logic [TMO_W-1:0]       tmo_q, tmo_d;
  logic [DIGIT_W-1:0]     digit_q, digit_d;
  logic [4*N_DIGITS-1:0]  digitos_q, digitos_d;
  logic [SCORE_W-1:0]     score_q, score_d;
  logic                   err_scan_q, err_scan_d;
  logic                   error_q, error_d;
  logic                   pending_q, pending_d;

  logic                   acc_clear;
  logic                   acc_en;
  logic                   digit_ok;
  logic [DIGIT_W-1:0]     acc_digit;
  logic [SCORE_W-1:0]     acc_val;

  // Invalid or timed-out digits contribute zero to the score
  assign digit_ok  = digit_is_valid(digit_q);
  assign acc_digit = digit_ok ? digit_q : '0;

  placar_acumulador #(
    .SCORE_W (SCORE_W)
  ) u_acumulador (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (acc_clear),
    .enable_i (acc_en),
    .digit_i  (acc_digit),
    .acc_o    (acc_val)
  );

  // Next-state and datapath control for the scan sequencer
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    tmo_d      = tmo_q;
    digit_d    = digit_q;
    digitos_d  = digitos_q;
    score_d    = score_q;
    err_scan_d = err_scan_q;
    error_d    = error_q;
    pending_d  = pending_q;
    acc_clear  = 1'b0;
    acc_en     = 1'b0;

    // A request arriving mid-scan is remembered once; repeats collapse
    if (trigger && (state_q != IDLE)) begin
      pending_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (trigger) begin
          acc_clear  = 1'b1;
          err_scan_d = 1'b0;
          idx_d      = IDX_MSD;
          state_d    = ISSUE;
        end
      end

      ISSUE: begin
        tmo_d   = '0;
        state_d = WAIT;
      end

      WAIT: begin
        // An engine answer in the last waiting cycle still beats the timeout
        if (eng_done) begin
          digit_d = eng_digit;
          state_d = CAPTURE;
        end else if (tmo_q == TMO_LAST) begin
          digit_d = INVALID_DIGIT;
          state_d = CAPTURE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      CAPTURE: begin
        for (int k = 0; k < N_DIGITS; k++) begin
          if (idx_q == 3'(k + 1)) begin
            digitos_d[k*DIGIT_W +: DIGIT_W] = digit_q;
          end
        end
        acc_en = 1'b1;
        if (!digit_ok) begin
          err_scan_d = 1'b1;
        end
        if (idx_q == 3'd1) begin
          error_d = err_scan_q | ~digit_ok;
          state_d = DONE;
        end else begin
          idx_d   = idx_q - 3'd1;
          state_d = ISSUE;
        end
      end

      DONE: begin
        // The completed score is sitting in the accumulator; keep a copy
        // before a back-to-back rescan clears it at this same edge
        score_d   = acc_val;
        pending_d = 1'b0;
        if (pending_q || trigger) begin
          acc_clear  = 1'b1;
          err_scan_d = 1'b0;
          idx_d      = IDX_MSD;
          state_d    = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer and datapath registers; reset aborts any scan in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= IDX_MSD;
      tmo_q      <= '0;
      digit_q    <= '0;
      digitos_q  <= '0;
      score_q    <= '0;
      err_scan_q <= 1'b0;
      error_q    <= 1'b0;
      pending_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      tmo_q      <= tmo_d;
      digit_q    <= digit_d;
      digitos_q  <= digitos_d;
      score_q    <= score_d;
      err_scan_q <= err_scan_d;
      error_q    <= error_d;
      pending_q  <= pending_d;
    end
  end

  assign eng_start   = (state_q == ISSUE);
  assign eng_sel     = idx_q;
  assign busy        = (state_q != IDLE);
  assign score_valid = (state_q == DONE);
  assign digitos     = digitos_q;
  assign error       = error_q;
  // During the completion cycle the fresh score comes straight from the
  // accumulator; afterwards the held copy is shown until the next completion
  assign score       = (state_q == DONE) ? acc_val : score_q;

endmodule : escalonador_placar
`default_nettype wire
